// File: rtl/sp_ram_fifo_ctrl_if.sv
// Bundle of producer, consumer and RAM-side signals for sp_ram_fifo_ctrl.
// The slave modport is the controller's view. The master modport is the view of
// whatever surrounds it: the producer, the consumer and the RAM.
// Optional macro SP_FIFO_ALMOST_FULL_EN adds the o_Almost_Full signal.
interface sp_ram_fifo_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;

    // producer side
    logic             i_Wr_DV;
    logic [WIDTH-1:0] i_Wr_Data;
    logic             o_Wr_Ready;
    // consumer side
    logic             o_Rd_DV;
    logic [WIDTH-1:0] o_Rd_Data;
    logic             i_Rd_Ready;
    // status
    logic [CW-1:0]    o_Count;
    logic             o_Empty;
    logic             o_Full;
`ifdef SP_FIFO_ALMOST_FULL_EN
    logic             o_Almost_Full;
`endif
    // RAM side
    logic [AW-1:0]    o_Ram_Addr;
    logic             o_Ram_Wr_DV;
    logic [WIDTH-1:0] o_Ram_Wr_Data;
    logic             o_Ram_Rd_En;
    logic [WIDTH-1:0] i_Ram_Rd_Data;

    modport slave (
        input  i_Wr_DV, i_Wr_Data, i_Rd_Ready, i_Ram_Rd_Data,
        output o_Wr_Ready, o_Rd_DV, o_Rd_Data, o_Count, o_Empty, o_Full,
               o_Ram_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_En
`ifdef SP_FIFO_ALMOST_FULL_EN
      , output o_Almost_Full
`endif
    );

    modport master (
        output i_Wr_DV, i_Wr_Data, i_Rd_Ready, i_Ram_Rd_Data,
        input  o_Wr_Ready, o_Rd_DV, o_Rd_Data, o_Count, o_Empty, o_Full,
               o_Ram_Addr, o_Ram_Wr_DV, o_Ram_Wr_Data, o_Ram_Rd_En
`ifdef SP_FIFO_ALMOST_FULL_EN
      , input  o_Almost_Full
`endif
    );
endinterface

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller in front of a single-port RAM.
// The RAM has a combinational read and a registered write. Each cycle the one
// RAM port goes either to a producer write or to a head-word prefetch into a
// first-word-fall-through output register. When both want the port they take
// turns (round robin).
// Optional macro SP_FIFO_ALMOST_FULL_EN adds a registered o_Almost_Full output.
// That output compares the next-state o_Count against ALMOST_FULL_LEVEL.
module sp_ram_fifo_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
`ifdef SP_FIFO_ALMOST_FULL_EN
  , parameter int ALMOST_FULL_LEVEL = DEPTH - 2
`endif
) (
    input logic               i_Clk,
    input logic               i_Rst_L,
    sp_ram_fifo_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 2;
    localparam logic [AW:0]   RAM_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      ram_count, ram_count_nxt;
    logic             out_valid, out_valid_nxt;
    logic             rr;
    logic [WIDTH-1:0] rd_data_q;

    logic rd_pend, wr_pend, rd_grant, wr_grant, pop;

    // Request detection and single-port arbitration (rr=0 favours the read).
    // NOTE: combinational blocks use blocking '=' and flops use '<='. This way
    // every flop samples values from before the clock edge.
    always_comb begin
        rd_pend  = (ram_count != '0) && (!out_valid || bus.i_Rd_Ready);
        wr_pend  = bus.i_Wr_DV && (ram_count != RAM_FULL);
        rd_grant = rd_pend && (!wr_pend || !rr);
        wr_grant = wr_pend && (!rd_pend || rr);
        pop      = out_valid && bus.i_Rd_Ready;
    end

    // Next-state count and output-valid. The grants are mutually exclusive.
    always_comb begin
        ram_count_nxt = ram_count;
        if (wr_grant)
            ram_count_nxt = ram_count + CNT_ONE;
        else if (rd_grant)
            ram_count_nxt = ram_count - CNT_ONE;

        out_valid_nxt = out_valid;
        if (rd_grant)
            out_valid_nxt = 1'b1;
        else if (pop)
            out_valid_nxt = 1'b0;
    end

    // RAM port drive. The strobes are gated so nothing reaches the RAM during reset.
    // NOTE: each output gets a default first, so no branch can infer a latch.
    always_comb begin
        bus.o_Ram_Addr    = rd_ptr;
        bus.o_Ram_Wr_DV   = 1'b0;
        bus.o_Ram_Rd_En   = 1'b0;
        bus.o_Ram_Wr_Data = bus.i_Wr_Data;
        if (wr_grant) begin
            bus.o_Ram_Addr  = wr_ptr;
            bus.o_Ram_Wr_DV = i_Rst_L;
        end else if (rd_grant) begin
            bus.o_Ram_Rd_En = i_Rst_L;
        end
    end

    // Pointers, occupancy, output register and round-robin flag.
    // NOTE: the RAM array is outside this block and is deliberately not cleared.
    // Resetting the pointers and the count is enough to make its stale contents
    // unreachable.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            out_valid <= 1'b0;
            rd_data_q <= '0;
            rr        <= 1'b0;
        end else begin
            if (wr_grant)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_grant) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                rd_data_q <= bus.i_Ram_Rd_Data;
            end
            ram_count <= ram_count_nxt;
            out_valid <= out_valid_nxt;
            if (rd_pend && wr_pend)
                rr <= ~rr;
        end
    end

`ifdef SP_FIFO_ALMOST_FULL_EN
    localparam logic [CW-1:0] AF_LEVEL = CW'(ALMOST_FULL_LEVEL);
    logic almost_full_q;

    // Almost-full flag, registered from the count the FIFO will hold after this edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L)
            almost_full_q <= 1'b0;
        else
            almost_full_q <= (CW'(ram_count_nxt) + CW'(out_valid_nxt)) >= AF_LEVEL;
    end

    assign bus.o_Almost_Full = almost_full_q;
`endif

    assign bus.o_Wr_Ready = (ram_count != RAM_FULL) && !(rd_pend && !rr);
    assign bus.o_Rd_DV    = out_valid;
    assign bus.o_Rd_Data  = rd_data_q;
    assign bus.o_Count    = CW'(ram_count) + CW'(out_valid);
    assign bus.o_Empty    = !out_valid;
    assign bus.o_Full     = (ram_count == RAM_FULL);

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Self-checking bench for sp_ram_fifo_ctrl with WIDTH=16 and DEPTH=4.
// Accepted words go into a scoreboard queue. Popped words are compared
// against the front of that queue.
// Define SP_FIFO_ALMOST_FULL_EN to also exercise o_Almost_Full (level 3).
module tb_sp_ram_fifo_ctrl;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic i_Clk = 1'b0;
    logic i_Rst_L = 1'b0;

    sp_ram_fifo_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sp_ram_fifo_ctrl #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
`ifdef SP_FIFO_ALMOST_FULL_EN
      , .ALMOST_FULL_LEVEL(3)
`endif
    ) dut (
        .i_Clk  (i_Clk),
        .i_Rst_L(i_Rst_L),
        .bus    (bus)
    );

    always #5 i_Clk = ~i_Clk;

    // Behavioural single-port RAM: combinational read, registered write.
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    always @(posedge i_Clk)
        if (bus.o_Ram_Wr_DV) mem[bus.o_Ram_Addr] <= bus.o_Ram_Wr_Data;
    assign bus.i_Ram_Rd_Data = mem[bus.o_Ram_Addr];

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] sb[$];
    logic last_acc, last_pop;
    int n_popped, n_rd_grant, n_wr_grant, both_seen, idx;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a negedge with the inputs already applied. Samples the
    // handshakes before the rising edge, then waits for the next negedge.
    task automatic tick();
        logic [WIDTH-1:0] exp;
        #1;
        last_acc = bus.i_Wr_DV && bus.o_Wr_Ready;
        last_pop = bus.o_Rd_DV && bus.i_Rd_Ready;
        if (bus.o_Ram_Wr_DV && bus.o_Ram_Rd_En) both_seen++;
        if (bus.o_Ram_Rd_En) n_rd_grant++;
        if (bus.o_Ram_Wr_DV) n_wr_grant++;
        if (last_pop) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("rd_data", bus.o_Rd_Data, exp);
                n_popped++;
            end
        end
        if (last_acc) sb.push_back(bus.i_Wr_Data);
        @(negedge i_Clk);
    endtask

    task automatic do_reset();
        bus.i_Wr_DV = 1'b0;
        bus.i_Wr_Data = '0;
        bus.i_Rd_Ready = 1'b0;
        i_Rst_L = 1'b0;
        repeat (2) @(negedge i_Clk);
        i_Rst_L = 1'b1;
        sb.delete();
        n_popped = 0; n_rd_grant = 0; n_wr_grant = 0; both_seen = 0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Data = d;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (last_acc) break;
        end
        check("wr_accept", last_acc, 1);
        bus.i_Wr_DV = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bus.i_Rd_Ready = 1'b1;
        for (int k = 0; k < max_cycles; k++) begin
            if (sb.size() == 0 && !bus.o_Rd_DV) break;
            tick();
        end
        bus.i_Rd_Ready = 1'b0;
        check("drain_sb_empty", sb.size(), 0);
        check("drain_rd_dv", bus.o_Rd_DV, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge i_Clk);
        do_reset();

        // Test 1: reset state, then a single write with the consumer stalled.
        check("rst_count", bus.o_Count, 0);
        check("rst_empty", bus.o_Empty, 1);
        check("rst_full", bus.o_Full, 0);
        check("rst_rd_dv", bus.o_Rd_DV, 0);
        check("rst_rd_data", bus.o_Rd_Data, 0);
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Data = 16'h1111;
        #1 check("t1_wr_ready", bus.o_Wr_Ready, 1);
        tick();
        check("t1_acc", last_acc, 1);
        bus.i_Wr_DV = 1'b0;
        check("t1_dv_edge1", bus.o_Rd_DV, 0);
        tick();
        check("t1_dv_edge2", bus.o_Rd_DV, 1);
        check("t1_data", bus.o_Rd_Data, 16'h1111);
        check("t1_count", bus.o_Count, 1);

        // Test 2: fill to DEPTH+1, a held sixth write, one pop, then drain in order.
        do_reset();
        for (int i = 0; i < 5; i++) push_word(16'hA000 + 16'(i));
        check("t2_full", bus.o_Full, 1);
        check("t2_wr_ready", bus.o_Wr_Ready, 0);
        check("t2_count", bus.o_Count, 5);
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Data = 16'hA005;
        tick(); check("t2_held1", last_acc, 0);
        tick(); check("t2_held2", last_acc, 0);
        bus.i_Rd_Ready = 1'b1;
        #1 check("t2_ready_at_pop", bus.o_Wr_Ready, 0);
        tick();
        check("t2_pop", last_pop, 1);
        bus.i_Rd_Ready = 1'b0;
        #1 check("t2_ready_after_pop", bus.o_Wr_Ready, 1);
        tick();
        check("t2_acc6", last_acc, 1);
        bus.i_Wr_DV = 1'b0;
        check("t2_count_again", bus.o_Count, 5);
        drain(40);
        check("t2_popped", n_popped, 6);

        // Test 3: continuous write and read contention with pointer wrap.
        do_reset();
        bus.i_Rd_Ready = 1'b1;
        idx = 0;
        for (int k = 0; k < 200; k++) begin
            if (idx == 20 && sb.size() == 0 && !bus.o_Rd_DV) break;
            bus.i_Wr_DV = (idx < 20);
            bus.i_Wr_Data = 16'h3000 + 16'(idx);
            tick();
            if (last_acc) idx++;
        end
        bus.i_Wr_DV = 1'b0;
        bus.i_Rd_Ready = 1'b0;
        check("t3_written", idx, 20);
        check("t3_popped", n_popped, 20);
        check("t3_both_strobes", both_seen, 0);
        check("t3_wr_grants", n_wr_grant, 20);
        check("t3_rd_grants", n_rd_grant, 20);

        // Test 4: three words popped back to back, then idle and empty.
        do_reset();
        for (int i = 0; i < 3; i++) push_word(16'h4000 + 16'(i));
        check("t4_count3", bus.o_Count, 3);
        bus.i_Rd_Ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_b2b_pop", last_pop, 1);
        end
        check("t4_empty", bus.o_Empty, 1);
        check("t4_count0", bus.o_Count, 0);
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_no_rd_en", bus.o_Ram_Rd_En, 0);
            tick();
        end
        bus.i_Rd_Ready = 1'b0;

        // Test 5: asynchronous reset mid-stream, then a fresh word comes out first.
        do_reset();
        for (int i = 0; i < 3; i++) push_word(16'h5000 + 16'(i));
        check("t5_count3", bus.o_Count, 3);
        bus.i_Wr_DV = 1'b1;
        bus.i_Wr_Data = 16'h5555;
        #3 i_Rst_L = 1'b0;
        #1;
        check("t5_rd_dv", bus.o_Rd_DV, 0);
        check("t5_count", bus.o_Count, 0);
        check("t5_rd_data", bus.o_Rd_Data, 0);
        check("t5_wr_strobe", bus.o_Ram_Wr_DV, 0);
        check("t5_rd_strobe", bus.o_Ram_Rd_En, 0);
        @(negedge i_Clk);
        do_reset();
        push_word(16'hBEEF);
        tick();
        check("t5_first_word", bus.o_Rd_Data, 16'hBEEF);
        drain(20);

`ifdef SP_FIFO_ALMOST_FULL_EN
        // Test 6: the almost-full flag tracks o_Count crossing level 3.
        do_reset();
        check("t6_af_rst", bus.o_Almost_Full, 0);
        push_word(16'h6000);
        push_word(16'h6001);
        check("t6_af_at2", bus.o_Almost_Full, 0);
        push_word(16'h6002);
        check("t6_count3", bus.o_Count, 3);
        check("t6_af_at3", bus.o_Almost_Full, 1);
        bus.i_Rd_Ready = 1'b1;
        tick();
        bus.i_Rd_Ready = 1'b0;
        check("t6_count2", bus.o_Count, 2);
        check("t6_af_back2", bus.o_Almost_Full, 0);
        drain(20);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
